// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, cmov/jXX evaluation and the M pipeline register.
// Optional EXEC_MUL_EN adds OPq ifun 4 = signed mulq; otherwise OPq ifun 4..F is an invalid instruction.
module execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valC,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [1:0]  m_stat,
    input  logic [1:0]  W_stat,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic        e_Cnd,
    output logic [1:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [2:0]  cc
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned NW   = 4;
    localparam int unsigned SW   = 2;

    localparam logic [NW-1:0] I_NOP    = 4'h1;
    localparam logic [NW-1:0] I_RRMOVQ = 4'h2;
    localparam logic [NW-1:0] I_IRMOVQ = 4'h3;
    localparam logic [NW-1:0] I_RMMOVQ = 4'h4;
    localparam logic [NW-1:0] I_MRMOVQ = 4'h5;
    localparam logic [NW-1:0] I_OPQ    = 4'h6;
    localparam logic [NW-1:0] I_JXX    = 4'h7;
    localparam logic [NW-1:0] I_CALL   = 4'h8;
    localparam logic [NW-1:0] I_RET    = 4'h9;
    localparam logic [NW-1:0] I_PUSHQ  = 4'hA;
    localparam logic [NW-1:0] I_POPQ   = 4'hB;
    localparam logic [NW-1:0] R_NONE   = 4'hF;

    localparam logic [SW-1:0] S_AOK = 2'b00;
    localparam logic [SW-1:0] S_INS = 2'b10;

    localparam logic [NW-1:0] A_ADD = 4'h0;
    localparam logic [NW-1:0] A_SUB = 4'h1;
    localparam logic [NW-1:0] A_AND = 4'h2;
    localparam logic [NW-1:0] A_XOR = 4'h3;
`ifdef EXEC_MUL_EN
    localparam logic [NW-1:0] A_MUL     = 4'h4;
    localparam logic [NW-1:0] A_MAX_FUN = 4'h4;
`else
    localparam logic [NW-1:0] A_MAX_FUN = 4'h3;
`endif

    localparam logic [XLEN-1:0] STACK_STEP = XLEN'(8);

    logic [XLEN-1:0] alu_a, alu_b, alu_res;
    logic [NW-1:0]   alu_fn;
    logic            op_bad;
    logic            zf, sf, of;
    logic            cc_upd;
    logic            cond;
    logic [2:0]      cc_d, cc_q;

    logic [SW-1:0]   stat_d, stat_q;
    logic [NW-1:0]   icode_d, icode_q;
    logic            cnd_d, cnd_q;
    logic [XLEN-1:0] vale_d, vale_q;
    logic [XLEN-1:0] vala_d, vala_q;
    logic [NW-1:0]   dste_d, dste_q;
    logic [NW-1:0]   dstm_d, dstm_q;

`ifdef EXEC_MUL_EN
    logic signed [2*XLEN-1:0] prod;
`endif

    // Operand selection by instruction class
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:           alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ,
            I_MRMOVQ:                  alu_a = E_valC;
            I_CALL, I_PUSHQ:           alu_a = XLEN'(0) - STACK_STEP;
            I_RET, I_POPQ:             alu_a = STACK_STEP;
            default:                   alu_a = '0;
        endcase
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_RET,
            I_PUSHQ, I_POPQ:           alu_b = E_valB;
            default:                   alu_b = '0;
        endcase
    end

    assign alu_fn = (E_icode == I_OPQ) ? E_ifun : A_ADD;
    assign op_bad = (E_icode == I_OPQ) && (E_ifun > A_MAX_FUN);

    // ALU with overflow detection; unsupported functions yield zero
    always_comb begin
        alu_res = '0;
        of      = 1'b0;
`ifdef EXEC_MUL_EN
        prod    = '0;
`endif
        case (alu_fn)
            A_ADD: begin
                alu_res = alu_b + alu_a;
                of      = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_a[XLEN-1]);
            end
            A_SUB: begin
                alu_res = alu_b - alu_a;
                of      = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (alu_res[XLEN-1] != alu_b[XLEN-1]);
            end
            A_AND:   alu_res = alu_a & alu_b;
            A_XOR:   alu_res = alu_a ^ alu_b;
`ifdef EXEC_MUL_EN
            A_MUL: begin
                prod    = $signed({{XLEN{alu_a[XLEN-1]}}, alu_a}) * $signed({{XLEN{alu_b[XLEN-1]}}, alu_b});
                alu_res = prod[XLEN-1:0];
                of      = (prod[2*XLEN-1:XLEN] != {XLEN{prod[XLEN-1]}});
            end
`endif
            default: begin
                alu_res = '0;
                of      = 1'b0;
            end
        endcase
    end

    assign zf     = (alu_res == '0);
    assign sf     = alu_res[XLEN-1];
    assign e_valE = alu_res;

    // Flags are frozen while an exception is draining through M or W
    assign cc_upd = (E_icode == I_OPQ) && !op_bad && (E_stat == S_AOK)
                 && (m_stat == S_AOK) && (W_stat == S_AOK);
    assign cc_d   = cc_upd ? {zf, sf, of} : cc_q;

    // Branch/move condition from the flags held before this cycle's update
    always_comb begin
        cond = 1'b0;
        case (E_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2:    cond = cc_q[1] ^ cc_q[0];
            4'h3:    cond = cc_q[2];
            4'h4:    cond = !cc_q[2];
            4'h5:    cond = !(cc_q[1] ^ cc_q[0]);
            4'h6:    cond = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
            default: cond = 1'b0;
        endcase
    end

    assign e_Cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond : 1'b0;
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? R_NONE : E_dstE;

    // M register next state; a bubble inserts a nop
    always_comb begin
        stat_d  = S_AOK;
        icode_d = I_NOP;
        cnd_d   = 1'b0;
        vale_d  = '0;
        vala_d  = '0;
        dste_d  = R_NONE;
        dstm_d  = R_NONE;
        if (!M_bubble) begin
            stat_d  = op_bad ? S_INS : E_stat;
            icode_d = E_icode;
            cnd_d   = e_Cnd;
            vale_d  = e_valE;
            vala_d  = E_valA;
            dste_d  = e_dstE;
            dstm_d  = E_dstM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q    <= 3'b100;
            stat_q  <= S_AOK;
            icode_q <= I_NOP;
            cnd_q   <= 1'b0;
            vale_q  <= '0;
            vala_q  <= '0;
            dste_q  <= R_NONE;
            dstm_q  <= R_NONE;
        end else begin
            cc_q    <= cc_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            vale_q  <= vale_d;
            vala_q  <= vala_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
        end
    end

    assign cc      = cc_q;
    assign M_stat  = stat_q;
    assign M_icode = icode_q;
    assign M_Cnd   = cnd_q;
    assign M_valE  = vale_q;
    assign M_valA  = vala_q;
    assign M_dstE  = dste_q;
    assign M_dstM  = dstm_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed Y86-64 sequences plus randomized traffic
// against an instruction-level reference model; honours EXEC_MUL_EN like the design.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  E_stat, m_stat, W_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        M_bubble;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
    logic        e_Cnd, M_Cnd;
    logic [1:0]  M_stat;
    logic [2:0]  cc;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc(cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [2:0]  cc;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [2:0] cc_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 6))
            0: return 64'h0;
            1: return 64'h1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Instruction-level reference: what execute must produce for one instruction
    task automatic model(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [1:0] ms, input logic [1:0] ws, input logic bub,
                         output logic [63:0] ev, output logic [3:0] ed, output logic ec,
                         output exp_t e);
        logic [63:0]  a, b;
        logic [64:0]  w;
        logic signed [127:0] p;
        logic         bad, zf, sf, of, taken;
        int           kind;
        a = 64'h0; b = 64'h0; of = 1'b0; ev = 64'h0;
        if (ic == 4'h2 || ic == 4'h6) a = va;
        else if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) a = vc;
        else if (ic == 4'h8 || ic == 4'hA) a = 64'hFFFF_FFFF_FFFF_FFF8;
        else if (ic == 4'h9 || ic == 4'hB) a = 64'd8;
        if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) b = vb;
        kind = (ic == 4'h6) ? int'(fn) : 0;
`ifdef EXEC_MUL_EN
        bad = (ic == 4'h6) && (fn > 4'd4);
`else
        bad = (ic == 4'h6) && (fn > 4'd3);
`endif
        if (!bad) begin
            case (kind)
                0: begin w = {b[63], b} + {a[63], a}; ev = w[63:0]; of = w[64] != w[63]; end
                1: begin w = {b[63], b} - {a[63], a}; ev = w[63:0]; of = w[64] != w[63]; end
                2: ev = a & b;
                3: ev = a ^ b;
                4: begin
                    p  = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                    ev = p[63:0];
                    of = (p > 128'sh7FFF_FFFF_FFFF_FFFF) || (p < -128'sh8000_0000_0000_0000);
                end
                default: ev = 64'h0;
            endcase
        end
        zf = cc_m[2]; sf = cc_m[1];
        case (fn)
            4'h0: taken = 1'b1;
            4'h1: taken = (sf != cc_m[0]) || zf;
            4'h2: taken = (sf != cc_m[0]);
            4'h3: taken = zf;
            4'h4: taken = !zf;
            4'h5: taken = (sf == cc_m[0]);
            4'h6: taken = (sf == cc_m[0]) && !zf;
            default: taken = 1'b0;
        endcase
        ec = (ic == 4'h2 || ic == 4'h7) ? taken : 1'b0;
        ed = (ic == 4'h2 && !ec) ? 4'hF : de;
        if (ic == 4'h6 && !bad && st == 2'b00 && ms == 2'b00 && ws == 2'b00)
            cc_m = {ev == 64'h0, ev[63], of};
        e.cc = cc_m;
        if (bub) begin
            e.stat = 2'b00; e.icode = 4'h1; e.cnd = 1'b0; e.vale = 64'h0;
            e.vala = 64'h0; e.dste = 4'hF; e.dstm = 4'hF;
        end else begin
            e.stat = bad ? 2'b10 : st; e.icode = ic; e.cnd = ec; e.vale = ev;
            e.vala = va; e.dste = ed; e.dstm = dm;
        end
    endtask

    task automatic set_nop();
        E_stat = 2'b00; E_icode = 4'h1; E_ifun = 4'h0;
        E_valC = 64'h0; E_valA = 64'h0; E_valB = 64'h0;
        E_dstE = 4'hF; E_dstM = 4'hF; m_stat = 2'b00; W_stat = 2'b00; M_bubble = 1'b0;
    endtask

    task automatic issue(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [1:0] ms, input logic [1:0] ws, input logic bub);
        logic [63:0] ev; logic [3:0] ed; logic ec; exp_t e;
        @(negedge clk);
        E_stat = st; E_icode = ic; E_ifun = fn; E_valC = vc; E_valA = va; E_valB = vb;
        E_dstE = de; E_dstM = dm; m_stat = ms; W_stat = ws; M_bubble = bub;
        model(st, ic, fn, vc, va, vb, de, dm, ms, ws, bub, ev, ed, ec, e);
        #1;
        chk("e_valE", e_valE, ev);
        chk("e_dstE", 64'(e_dstE), 64'(ed));
        chk("e_Cnd", 64'(e_Cnd), 64'(ec));
        sb.push_back(e);
    endtask

    task automatic op(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                      input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de);
        issue(2'b00, ic, fn, vc, va, vb, de, 4'hF, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic chk_reset_state();
        chk("rst M_stat", 64'(M_stat), 64'h0);
        chk("rst M_icode", 64'(M_icode), 64'h1);
        chk("rst M_Cnd", 64'(M_Cnd), 64'h0);
        chk("rst M_valE", M_valE, 64'h0);
        chk("rst M_valA", M_valA, 64'h0);
        chk("rst M_dstE", 64'(M_dstE), 64'hF);
        chk("rst M_dstM", 64'(M_dstM), 64'hF);
        chk("rst cc", 64'(cc), 64'h4);
    endtask

    // Monitor: the M register presents a new result after every edge that had an issue behind it
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("M_stat", 64'(M_stat), 64'(e.stat));
            chk("M_icode", 64'(M_icode), 64'(e.icode));
            chk("M_Cnd", 64'(M_Cnd), 64'(e.cnd));
            chk("M_valE", M_valE, e.vale);
            chk("M_valA", M_valA, e.vala);
            chk("M_dstE", 64'(M_dstE), 64'(e.dste));
            chk("M_dstM", 64'(M_dstM), 64'(e.dstm));
            chk("cc", 64'(cc), 64'(e.cc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] st, ms, ws;
        logic [3:0] ic, fn;
        set_nop();
        rst_n = 1'b0;
        cc_m  = 3'b100;
        #12;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        op(4'h6, 4'h0, 64'h0, 64'd5, 64'd7, 4'h2);                    // addq -> 12, cc 000
        op(4'h6, 4'h1, 64'h0, 64'd1, 64'd1, 4'h2);                    // subq -> 0, cc 100
        op(4'h2, 4'h3, 64'h0, 64'd9, 64'h0, 4'h3);                    // cmove taken
        op(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h1);
        op(4'h7, 4'h2, 64'h400, 64'h0, 64'h0, 4'hF);                  // jl not taken
        op(4'hA, 4'h0, 64'h0, 64'h55, 64'h100, 4'h4);                 // pushq
        op(4'hB, 4'h0, 64'h0, 64'h0, 64'hF8, 4'h4);                   // popq
        issue(2'b00, 4'h6, 4'h0, 64'h0, 64'd3, 64'd4, 4'h5, 4'hF, 2'b11, 2'b00, 1'b0);
        issue(2'b00, 4'h6, 4'h0, 64'h0, 64'd3, 64'd4, 4'h5, 4'hF, 2'b00, 2'b00, 1'b1);
        op(4'h6, 4'h1, 64'h0, 64'd6, 64'd6, 4'h2);                    // force ZF=1
        op(4'h2, 4'h4, 64'h0, 64'd11, 64'h0, 4'h4);                   // cmovne not taken
        op(4'h6, 4'h4, 64'h0, 64'd3, 64'd5, 4'h6);                    // OPq ifun 4
        op(4'h6, 4'h9, 64'h0, 64'd3, 64'd5, 4'h6);                    // OPq ifun 9 (always invalid)
        op(4'h3, 4'h0, 64'hDEAD, 64'h0, 64'h0, 4'h7);                 // irmovq
        op(4'h5, 4'h0, 64'h10, 64'h0, 64'h20, 4'hF);                  // mrmovq address

        for (int n = 0; n < 400; n++) begin
            ic = 4'($urandom_range(0, 11));
            if (ic == 4'h6)      fn = 4'($urandom_range(0, 5));
            else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 8));
            else                 fn = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ms = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ws = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            issue(st, ic, fn, rand64(), rand64(), rand64(), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), ms, ws, ($urandom_range(0, 9) == 0));
            if (n == 200) begin
                @(negedge clk);
                set_nop();
                rst_n = 1'b0;
                #1;
                chk_reset_state();
                cc_m = 3'b100;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        set_nop();
        @(negedge clk);
        chk("scoreboard drained", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline execute stage; sits between the decode pipeline register (E_*) and the memory stage.
- Computes the ALU result (valE), maintains the condition-code register (ZF/SF/OF), and evaluates cmov/jXX conditions.
- Drives combinational forwarding outputs (e_*) and the M pipeline register that feeds the memory stage.
- Honours the bubble request from pipeline control.

Parameters:
- none. Widths are fixed: 64-bit data, 4-bit icode/ifun/register IDs, 2-bit stat.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- E_stat  input  2  status: AOK=00, HLT=01, INS=10, ADR=11
- E_icode, E_ifun  input  4 each  instruction code / function
- E_valC, E_valA, E_valB  input  64 each  constant and decoded operands
- E_dstE, E_dstM  input  4 each  destination register IDs (F = none)
- m_stat  input  2  current memory-stage status (from the memory stage)
- W_stat  input  2  current writeback-register status
- M_bubble  input  1  load a nop into the M register at the next edge
- e_valE  output  64  combinational ALU result (forwarding)
- e_dstE  output  4  combinational effective dstE (forwarding)
- e_Cnd  output  1  combinational condition result
- M_stat  output  2  M register: status
- M_icode  output  4  M register: instruction code
- M_Cnd  output  1  M register: condition result
- M_valE, M_valA  output  64 each  M register: ALU result / operand A
- M_dstE, M_dstM  output  4 each  M register: destination IDs
- cc  output  3  {ZF,SF,OF} register

Behaviour:
- Reset (rst_n low, asynchronous):
  - M_stat=00, M_icode=1 (nop), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=F, M_dstM=F.
  - cc=3'b100 (ZF=1, SF=0, OF=0).
  - Reset deasserting mid-stream resumes normally at the next edge.
- aluA selection:
  - icode 2, 6: E_valA
  - icode 3, 4, 5: E_valC
  - icode 8, A: -8
  - icode 9, B: +8
  - otherwise 0
- aluB selection:
  - icode 4, 5, 6, 8, 9, A, B: E_valB
  - icode 2, 3: 0
  - otherwise 0
- ALU function:
  - icode 6 uses E_ifun; all other icodes use add.
  - ifun 0: B+A; 1: B-A; 2: A&B; 3: A^B. All 64-bit, wrap modulo 2^64.
  - e_valE is the ALU output.
- Flags computed from the ALU result:
  - ZF = (valE==0); SF = valE[63].
  - OF for add: A[63]==B[63] && valE[63]!=A[63].
  - OF for sub: A[63]!=B[63] && valE[63]!=B[63].
  - OF for and/xor: 0.
- CC update: at the rising edge, only when all of the following hold:
  - E_icode==6
  - E_stat==AOK
  - m_stat==AOK and W_stat==AOK (no update in the shadow of an exception)
- Condition evaluation uses the CC value held before this cycle's update. Encoding by E_ifun:
  - 0: 1
  - 1 (le): (SF^OF)|ZF
  - 2 (l): SF^OF
  - 3 (e): ZF
  - 4 (ne): !ZF
  - 5 (ge): !(SF^OF)
  - 6 (g): !(SF^OF)&!ZF
  - ifun>6: 0
  - e_Cnd carries this result for icode 2 and 7; it is 0 for all other icodes.
- e_dstE = F when icode==2 and !e_Cnd; otherwise E_dstE.
- M register (rising edge):
  - M_bubble=1: load the reset values above; the CC update rule is unaffected.
  - Otherwise: M_stat<=E_stat, M_icode<=E_icode, M_Cnd<=e_Cnd, M_valE<=e_valE, M_valA<=E_valA, M_dstE<=e_dstE, M_dstM<=E_dstM.
- Latency: e_* outputs are combinational in the same cycle; M_* outputs follow after one edge.

Optional Feature:
- Macro: EXEC_MUL_EN.
- When defined: OPq ifun 4 = mulq.
  - valE = low 64 bits of the signed product.
  - OF=1 when the product is not representable in 64-bit signed.
  - ZF/SF derived from valE.
- When undefined, OPq ifun 4..F:
  - e_valE=0, no CC update.
  - M_stat forced to INS (10).
- With the macro defined, OPq ifun 5..F follow the undefined-case rule.

Test Plan:
- Reset → M_icode=1, M_dstE=F, cc=100; then release and issue addq valA=5, valB=7 → e_valE=12, cc=000 after the edge, M_valE=12.
- subq A=1, B=1 → valE=0, cc=100; following cmove with valA=9, dstE=3 → e_Cnd=1, e_dstE=3, M_valE=9.
- addq A=B=0x7FFF_FFFF_FFFF_FFFF → valE=0xFFFF_FFFF_FFFF_FFFE, cc=011; then jl (ifun 2) → M_Cnd=0.
- pushq valB=0x100 → e_valE=0xF8; popq valB=0xF8 → e_valE=0x100; cc unchanged for both.
- addq with m_stat=11 → M_valE updated, cc unchanged; addq with M_bubble=1 → M_icode=1, M_dstE=F, M_stat=00.
- cmovne when ZF=1, dstE=4 → e_Cnd=0, e_dstE=F; OPq ifun 4 without EXEC_MUL_EN → M_stat=10, M_valE=0.
